// File: rtl/awgn_stream_ctrl.sv
// Box-Muller noise control: seed load, generator reset and warm-up, sigma scaling into an output FIFO (AWGN_SAT_CNT_EN adds sat_cnt).
// Latency: pair captured at edge t+1 into the scale register, written to the FIFO and visible on out_data after edge t+2.
// Backpressure: valid/ready show-ahead output; a write to a full FIFO with no pop drops the pair and bumps overflow_cnt.
module awgn_stream_ctrl #(
    parameter int DW     = 16,
    parameter int SW     = 16,
    parameter int DEPTH  = 16,
    parameter int WARMUP = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic              seed_we,
    input  logic [31:0]       seed_in,
    output logic [191:0]      seed_out,
    output logic              gen_rst,
    input  logic              run_en,
    input  logic [DW-1:0]     noise_in1,
    input  logic [DW-1:0]     noise_in2,
    input  logic [SW-1:0]     sigma,
    output logic [2*DW-1:0]   out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic [15:0]       overflow_cnt
`ifdef AWGN_SAT_CNT_EN
    ,
    output logic [15:0]       sat_cnt
`endif
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int WCW = $clog2(WARMUP + 2);
    localparam int PW  = DW + SW + 1;
    localparam int RW  = DW + 5;
    localparam logic [PW-1:0] RND = PW'(1) << (SW - 5);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GRST, S_WARM, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [2:0]      idx;
    logic [WCW-1:0]  wcnt;
    logic [31:0]     seed_w [6];

    // Returns {clipped, value}: Q4 scale with round-half-up, clamped to DW bits.
    function automatic logic [DW:0] scale(input logic [DW-1:0] n, input logic [SW-1:0] s);
        logic signed [PW-1:0] p;
        logic signed [PW-1:0] q;
        logic [RW-1:0]        r;
        p = PW'($signed(n)) * PW'($signed({1'b0, s}));
        q = p + RND;
        r = RW'(q >>> (SW - 4));
        if (r[RW-1:DW-1] == {(RW-DW+1){r[RW-1]}})
            return {1'b0, r[DW-1:0]};
        else
            return {1'b1, r[RW-1], {(DW-1){~r[RW-1]}}};
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (cfg_start) state_d = S_LOAD;
            S_LOAD: if (!cfg_start && seed_we && idx == 3'd5) state_d = S_GRST;
            S_GRST: if (wcnt == WCW'(1)) state_d = S_WARM;
            S_WARM: if (wcnt == WCW'(WARMUP - 1)) state_d = S_RUN;
            S_RUN:  if (cfg_start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gen_rst = (state_q == S_WARM) || (state_q == S_RUN);
        busy    = (state_q == S_LOAD) || (state_q == S_GRST) || (state_q == S_WARM);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx  <= '0;
            wcnt <= '0;
            for (int i = 0; i < 6; i++) seed_w[i] <= '0;
        end else begin
            if (state_q == S_LOAD && !cfg_start && seed_we) begin
                seed_w[idx] <= seed_in;
                idx         <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else if (cfg_start && (state_q == S_IDLE || state_q == S_LOAD || state_q == S_RUN)) begin
                idx <= '0;
            end
            if ((state_q == S_GRST || state_q == S_WARM) && state_d == state_q)
                wcnt <= wcnt + WCW'(1);
            else
                wcnt <= '0;
        end
    end

    assign seed_out = {seed_w[5], seed_w[4], seed_w[3], seed_w[2], seed_w[1], seed_w[0]};

    logic [DW:0]      sc1, sc2;
    logic             cap;
    logic             pipe_vld;
    logic [2*DW-1:0]  pipe_dat;

    assign sc1 = scale(noise_in1, sigma);
    assign sc2 = scale(noise_in2, sigma);
    assign cap = (state_q == S_RUN) && run_en;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pipe_vld <= 1'b0;
            pipe_dat <= '0;
        end else begin
            pipe_vld <= cap;
            if (cap) pipe_dat <= {sc2[DW-1:0], sc1[DW-1:0]};
        end
    end

    logic [2*DW-1:0] mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   f_cnt;
    logic            wr, flush, pop, push, drop, full;

    // Scale-stage data is only committed while still in RUN; reseed flushes instead.
    assign flush     = (state_q == S_RUN) && cfg_start;
    assign wr        = pipe_vld && (state_q == S_RUN) && !cfg_start;
    assign out_valid = (f_cnt != '0);
    assign full      = (f_cnt == CW'(DEPTH));
    assign pop       = out_valid && out_ready;
    assign push      = wr && (!full || pop);
    assign drop      = wr && full && !pop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            f_cnt        <= '0;
            overflow_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= rd_ptr;
            f_cnt  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= pipe_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   f_cnt <= f_cnt + CW'(1);
                2'b01:   f_cnt <= f_cnt - CW'(1);
                default: ;
            endcase
            if (drop && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
        end
    end

    // When empty, the slot behind rd_ptr is the last entry popped, so out_data holds.
    always_comb begin
        out_data = out_valid ? mem[rd_ptr] : mem[rd_ptr - AW'(1)];
    end

`ifdef AWGN_SAT_CNT_EN
    logic [1:0]  clip_n;
    logic [16:0] sat_sum;
    assign clip_n  = {1'b0, sc1[DW]} + {1'b0, sc2[DW]};
    assign sat_sum = {1'b0, sat_cnt} + {15'd0, clip_n};

    always_ff @(posedge clk) begin
        if (!reset)   sat_cnt <= '0;
        else if (cap) sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_awgn_stream_ctrl.sv
// Scoreboard bench for awgn_stream_ctrl: expected pairs are queued at capture and compared on each FIFO pop.
module tb_awgn_stream_ctrl;

    localparam int DW = 16, SW = 16, DEPTH = 16, WARMUP = 32;

    logic          clk, reset, cfg_start, seed_we, run_en, out_ready;
    logic [31:0]   seed_in;
    logic [191:0]  seed_out;
    logic          gen_rst, out_valid, busy;
    logic [DW-1:0] noise_in1, noise_in2;
    logic [SW-1:0] sigma;
    logic [2*DW-1:0] out_data;
    logic [15:0]   overflow_cnt;
`ifdef AWGN_SAT_CNT_EN
    logic [15:0]   sat_cnt;
    int            exp_sat = 0;
`endif

    int checks = 0;
    int failures = 0;
    logic [31:0] sb_q[$];

    awgn_stream_ctrl #(.DW(DW), .SW(SW), .DEPTH(DEPTH), .WARMUP(WARMUP)) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .seed_we(seed_we),
        .seed_in(seed_in), .seed_out(seed_out), .gen_rst(gen_rst), .run_en(run_en),
        .noise_in1(noise_in1), .noise_in2(noise_in2), .sigma(sigma),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .overflow_cnt(overflow_cnt)
`ifdef AWGN_SAT_CNT_EN
        , .sat_cnt(sat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: signed sample times Q4.12 sigma, round half up, clamp to 16 bits.
    function automatic logic [16:0] mdl(input logic [15:0] n, input logic [15:0] s);
        longint p, r;
        p = longint'($signed(n)) * longint'(s);
        r = (p + 2048) >>> 12;
        if (r > 32767)  return {1'b1, 16'h7FFF};
        if (r < -32768) return {1'b1, 16'h8000};
        return {1'b0, r[15:0]};
    endfunction

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) check_val("sb_extra_pop", sb_q.size(), 1);
            else                  check_val("sb_data", out_data, sb_q.pop_front());
        end
    end

    task automatic drive_pair(input logic [15:0] n1, input logic [15:0] n2);
        logic [16:0] a, b;
        a = mdl(n1, sigma);
        b = mdl(n2, sigma);
`ifdef AWGN_SAT_CNT_EN
        exp_sat = exp_sat + int'(a[16]) + int'(b[16]);
        if (exp_sat > 65535) exp_sat = 65535;
`endif
        noise_in1 = n1;
        noise_in2 = n2;
        run_en    = 1'b1;
        tick();
        run_en    = 1'b0;
    endtask

    task automatic send(input logic [15:0] n1, input logic [15:0] n2, input bit keep);
        logic [16:0] a, b;
        a = mdl(n1, sigma);
        b = mdl(n2, sigma);
        if (keep) sb_q.push_back({b[15:0], a[15:0]});
        drive_pair(n1, n2);
    endtask

    task automatic send_exp(input logic [15:0] n1, input logic [15:0] n2, input logic [31:0] exp);
        sb_q.push_back(exp);
        drive_pair(n1, n2);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 100) begin
            n++;
            tick();
        end
        check_val(tag, sb_q.size(), 0);
    endtask

    task automatic load_seeds(input logic [31:0] base);
        for (int i = 0; i < 6; i++) begin
            seed_we = 1'b1;
            seed_in = base * (i + 1);
            tick();
        end
        seed_we = 1'b0;
    endtask

    initial begin
        logic [191:0] exp_seed;
        int n;

        reset = 1'b0; cfg_start = 1'b0; seed_we = 1'b0; seed_in = '0;
        run_en = 1'b0; out_ready = 1'b0; noise_in1 = '0; noise_in2 = '0; sigma = '0;
        repeat (3) tick();
        check_val("rst_gen_rst", gen_rst, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_valid", out_valid, 0);
        check_val("rst_data", out_data, 0);
        check_val("rst_seed", seed_out, 0);
        check_val("rst_ovf", overflow_cnt, 0);
`ifdef AWGN_SAT_CNT_EN
        check_val("rst_sat", sat_cnt, 0);
`endif
        reset = 1'b1;
        tick();

        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        check_val("load_busy", busy, 1);
        load_seeds(32'h11111111);
        for (int i = 0; i < 6; i++) exp_seed[i*32 +: 32] = 32'h11111111 * (i + 1);
        check_val("seed_out", seed_out, exp_seed);
        n = 0;
        while (!gen_rst && n < 10) begin n++; tick(); end
        check_val("grst_len", n, 2);
        n = 0;
        while (busy && n < 100) begin n++; tick(); end
        check_val("warm_len", n, WARMUP);
        check_val("run_gen_rst", gen_rst, 1);

        // Unity gain and two-cycle latency.
        sigma = 16'h1000;
        send_exp(16'h1234, 16'hEDCC, 32'hEDCC1234);
        check_val("lat_early", out_valid, 0);
        tick();
        check_val("lat_valid", out_valid, 1);
        check_val("unity_data", out_data, 32'hEDCC1234);
        out_ready = 1'b1;
        wait_drain("unity_drain");

        // Rounding and both saturation directions.
        sigma = 16'h0800;
        send_exp(16'h0003, 16'hFFFD, 32'hFFFF0002);
        sigma = 16'hF000;
        send_exp(16'h4000, 16'h0001, 32'h000F7FFF);
`ifdef AWGN_SAT_CNT_EN
        check_val("sat_one", sat_cnt, 1);
`endif
        send_exp(16'hC000, 16'h8000, 32'h80008000);
        wait_drain("round_drain");
`ifdef AWGN_SAT_CNT_EN
        check_val("sat_three", sat_cnt, 3);
`endif

        for (int i = 0; i < 24; i++) begin
            sigma = 16'($urandom);
            send(16'($urandom), 16'($urandom), 1'b1);
        end
        wait_drain("rand_drain");
`ifdef AWGN_SAT_CNT_EN
        check_val("sat_rand", sat_cnt, exp_sat);
`endif

        // Overflow: only the first DEPTH pairs survive.
        sigma = 16'h1000;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 5; i++) send(16'(i * 37 + 5), 16'(16'hF000 - i), i < DEPTH);
        tick(); tick();
        check_val("ovf_cnt", overflow_cnt, 5);
        check_val("ovf_valid", out_valid, 1);
        send(16'h0ABC, 16'h0DEF, 1'b1);
        out_ready = 1'b1;
        tick();
        check_val("ovf_hold", overflow_cnt, 5);
        wait_drain("ovf_drain");

        // Pause and drain.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'(100 + i), 16'(200 + i), 1'b1);
        tick();
        out_ready = 1'b1;
        n = 0;
        while (out_valid && n < 20) begin n++; tick(); end
        check_val("pause_pops", n, 4);
        check_val("pause_sb", sb_q.size(), 0);

        // Reseed in RUN flushes the FIFO and the in-flight pair.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(16'(300 + i), 16'(400 + i), 1'b1);
        tick();
        check_val("reseed_pre", out_valid, 1);
        cfg_start = 1'b1; run_en = 1'b1;
        tick();
        cfg_start = 1'b0; run_en = 1'b0;
        sb_q.delete();
        check_val("flush_valid", out_valid, 0);
        check_val("flush_gen_rst", gen_rst, 0);
        check_val("flush_busy", busy, 1);
        out_ready = 1'b1;
        tick();
        check_val("flush_pipe", out_valid, 0);

        // Reset during a partial load.
        seed_we = 1'b1; seed_in = 32'hAAAAAAAA; tick();
        seed_in = 32'hBBBBBBBB; tick();
        seed_we = 1'b0;
        check_val("part_seed", seed_out[63:0], 64'hBBBBBBBBAAAAAAAA);
        reset = 1'b0; tick(); reset = 1'b1;
`ifdef AWGN_SAT_CNT_EN
        exp_sat = 0;
        check_val("rst2_sat", sat_cnt, 0);
`endif
        check_val("rst2_seed", seed_out, 0);
        check_val("rst2_busy", busy, 0);
        check_val("rst2_ovf", overflow_cnt, 0);
        check_val("rst2_valid", out_valid, 0);
        seed_we = 1'b1; seed_in = 32'hDEADBEEF; tick(); seed_we = 1'b0;
        check_val("idle_we", seed_out, 0);

        // cfg_start inside LOAD restarts the word index.
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        seed_we = 1'b1; seed_in = 32'h12345678; tick();
        seed_in = 32'h9ABCDEF0; tick(); seed_we = 1'b0;
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        load_seeds(32'h01010101);
        for (int i = 0; i < 6; i++) exp_seed[i*32 +: 32] = 32'h01010101 * (i + 1);
        check_val("reload_seed", seed_out, exp_seed);
        check_val("reload_grst", gen_rst, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
